// File: rtl/axi_mm_sched_pkg.sv
// Shared types for the AXI-MM slave write-path scheduler.
//   aw_entry_t : one accepted write address as tracked by the AW queue {id, len}
//   w_state_e  : W-channel release state
//   beat_t     : burst beat counter, one bit wider than LEN so LEN=255 (256 beats) fits
package axi_mm_sched_pkg;

    localparam int ID_WIDTH  = 2;
    localparam int LEN_WIDTH = 8;
    localparam int BEAT_W    = LEN_WIDTH + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [LEN_WIDTH-1:0] len;
    } aw_entry_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } w_state_e;

    typedef logic [BEAT_W-1:0] beat_t;

    // True when the beat being transferred is the final beat of a burst of length len+1.
    function automatic logic is_last_beat(input beat_t beat, input logic [LEN_WIDTH-1:0] len);
        return beat == {1'b0, len};
    endfunction

endpackage

// File: rtl/axi_mm_sched_fifo.sv
// Synchronous FIFO of accepted AW entries.
//   clk, rst_n : clock and synchronous active-low reset (reset empties the queue)
//   push       : write wr_data at the tail
//   pop        : retire the head entry
//   wr_data    : entry to push
//   full/empty : occupancy flags (pointers carry one extra wrap bit)
//   head       : entry at the head of the queue
//   level      : current occupancy
module axi_mm_sched_fifo
    import axi_mm_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  aw_entry_t                wr_data,
    output logic                     full,
    output logic                     empty,
    output aw_entry_t                head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    aw_entry_t   mem_r [DEPTH];

    // Pointer update; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents are don't-care while outside the valid pointer window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Same index with differing wrap bits means the write pointer lapped the read pointer.
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/axi_mm_slave_wr_sched.sv
// Write-path scheduler between the logic-link AW/W streams and the user AXI write channels.
// Only handshake and sequencing fields pass through; payload buses bypass this block.
//   clk_wr, rst_wr_n               : clock, synchronous active-low reset
//   user_aw_vld/awid_in/awlen_in   : AW from logic link; user_aw_ready back to it
//   user_awvalid/user_awready      : AW handshake toward user AXI
//   user_w_vld/wid_in/wlast_in     : W from logic link; user_w_ready back to it
//   user_wvalid/user_wready        : W handshake toward user AXI
//   user_bvalid/user_bready        : observed B handshake, retires an outstanding write
//   wr_outstanding                 : accepted writes awaiting B
//   err_wlast/err_wid/err_b_unexp  : sticky protocol error flags, cleared only by reset
module axi_mm_slave_wr_sched
    import axi_mm_sched_pkg::*;
#(
    parameter int AW_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WIDTH        = axi_mm_sched_pkg::ID_WIDTH,
    parameter int LEN_WIDTH       = axi_mm_sched_pkg::LEN_WIDTH
) (
    input  logic                                 clk_wr,
    input  logic                                 rst_wr_n,
    input  logic                                 user_aw_vld,
    input  logic [ID_WIDTH-1:0]                  user_awid_in,
    input  logic [LEN_WIDTH-1:0]                 user_awlen_in,
    output logic                                 user_aw_ready,
    output logic                                 user_awvalid,
    input  logic                                 user_awready,
    input  logic                                 user_w_vld,
    input  logic [ID_WIDTH-1:0]                  user_wid_in,
    input  logic                                 user_wlast_in,
    output logic                                 user_w_ready,
    output logic                                 user_wvalid,
    input  logic                                 user_wready,
    input  logic                                 user_bvalid,
    input  logic                                 user_bready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding,
    output logic                                 err_wlast,
    output logic                                 err_wid,
    output logic                                 err_b_unexp
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
    localparam int LVL_W = $clog2(AW_DEPTH) + 1;

    logic             q_full_s;
    logic             q_empty_s;
    aw_entry_t        q_head_s;
    aw_entry_t        q_wr_data_s;
    logic [LVL_W-1:0] q_level_s;

    logic             can_aw_s;
    logic             aw_hs_s;
    logic             b_hs_s;
    logic             w_active_s;
    logic             w_hs_s;
    logic             last_beat_s;
    logic             pop_s;

    w_state_e         w_state_r;
    beat_t            beat_cnt_r;
    logic [OUT_W-1:0] outstanding_r;
    logic             err_wlast_r;
    logic             err_wid_r;
    logic             err_b_unexp_r;

    assign q_wr_data_s = '{id: user_awid_in, len: user_awlen_in};

    axi_mm_sched_fifo #(
        .DEPTH   (AW_DEPTH)
    ) u_aw_q (
        .clk     (clk_wr),
        .rst_n   (rst_wr_n),
        .push    (aw_hs_s),
        .pop     (pop_s),
        .wr_data (q_wr_data_s),
        .full    (q_full_s),
        .empty   (q_empty_s),
        .head    (q_head_s),
        .level   (q_level_s)
    );

    // W release: only while a burst is queued; the reset cycle produces no handshake.
    assign w_active_s  = rst_wr_n && (w_state_r == W_DATA) && !q_empty_s;
    assign last_beat_s = is_last_beat(beat_cnt_r, q_head_s.len);

    // W channel gating; ready is returned only alongside a presented valid.
    always_comb begin
        user_wvalid  = 1'b0;
        user_w_ready = 1'b0;
        if (w_active_s) begin
            user_wvalid  = user_w_vld;
            user_w_ready = user_wready & user_w_vld;
        end else begin
            user_wvalid  = 1'b0;
            user_w_ready = 1'b0;
        end
    end

    assign w_hs_s = user_wvalid & user_wready;
    assign pop_s  = w_hs_s & last_beat_s;

    // A pop in the same cycle frees a slot, so a full queue does not block the push.
    assign can_aw_s      = rst_wr_n && (!q_full_s || pop_s) &&
                           (outstanding_r < OUT_W'(MAX_OUTSTANDING));
    assign user_awvalid  = user_aw_vld & can_aw_s;
    assign user_aw_ready = user_awready & user_awvalid;
    assign aw_hs_s       = user_awvalid & user_awready;
    assign b_hs_s        = rst_wr_n & user_bvalid & user_bready;

    // W FSM and beat counter; the beat count alone decides where a burst ends.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            w_state_r  <= W_IDLE;
            beat_cnt_r <= '0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    beat_cnt_r <= '0;
                    if (aw_hs_s || !q_empty_s) begin
                        w_state_r <= W_DATA;
                    end else begin
                        w_state_r <= W_IDLE;
                    end
                end
                W_DATA: begin
                    if (w_hs_s && last_beat_s) begin
                        beat_cnt_r <= '0;
                        // Last entry leaves with nothing arriving behind it.
                        if ((q_level_s == LVL_W'(1)) && !aw_hs_s) begin
                            w_state_r <= W_IDLE;
                        end else begin
                            w_state_r <= W_DATA;
                        end
                    end else if (w_hs_s) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        w_state_r  <= W_DATA;
                    end else begin
                        w_state_r  <= W_DATA;
                    end
                end
                default: begin
                    w_state_r  <= W_IDLE;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    // Outstanding-write counter; a B with nothing outstanding leaves it at zero.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            outstanding_r <= '0;
        end else begin
            case ({aw_hs_s, b_hs_s})
                2'b10: outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01: begin
                    if (outstanding_r != OUT_W'(0)) begin
                        outstanding_r <= outstanding_r - OUT_W'(1);
                    end else begin
                        outstanding_r <= outstanding_r;
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            err_wlast_r   <= 1'b0;
            err_wid_r     <= 1'b0;
            err_b_unexp_r <= 1'b0;
        end else begin
            if (w_hs_s && (user_wlast_in != last_beat_s)) begin
                err_wlast_r <= 1'b1;
            end
            if (w_hs_s && (user_wid_in != q_head_s.id)) begin
                err_wid_r <= 1'b1;
            end
            if (b_hs_s && (outstanding_r == OUT_W'(0))) begin
                err_b_unexp_r <= 1'b1;
            end
        end
    end

    assign wr_outstanding = outstanding_r;
    assign err_wlast      = err_wlast_r;
    assign err_wid        = err_wid_r;
    assign err_b_unexp    = err_b_unexp_r;

endmodule
